alu_seq: RTL and testbench

- Parametrised, registered successor to the 8-bit combinational ALU: same 3-bit opcode set, generalised to WIDTH bits.
- Adds valid/ready handshakes on input and output, registered result and flags, and an iterative shifter (one bit per cycle).
- Sits between decode/register-read and writeback. Stalls the upstream stage while busy and holds its result under downstream backpressure.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_core.sv | 40 ++++
 rtl/alu_seq.sv | 163 ++++++++++++++++
 tb/tb_alu_seq.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode set, FSM states and opcode helpers.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_ADD = 3'b001,
    OP_XOR = 3'b010,
    OP_SLT = 3'b011,
    OP_SLL = 3'b100,
    OP_SRL = 3'b101,
    OP_SNE = 3'b110,
    OP_OVF = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift(alu_op_e op);
    return (op == OP_SLL) || (op == OP_SRL);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational datapath for the non-shift opcodes plus carry/overflow/zero flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             ovf
);

  logic [WIDTH:0] sum;
  logic           ovf_raw;

  assign sum     = {1'b0, a} + {1'b0, b};
  assign ovf_raw = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

  // Shift opcodes fall through to zero; the sequencer supplies their result.
  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result    = a & b;
      OP_ADD:  result    = sum[WIDTH-1:0];
      OP_XOR:  result    = a ^ b;
      OP_SLT:  result[0] = (a < b);
      OP_SNE:  result[0] = (a != b);
      OP_OVF:  result[0] = ovf_raw;
      default: result    = '0;
    endcase
  end

  assign zero  = ~|result;
  assign carry = (op == OP_ADD) && sum[WIDTH];
  assign ovf   = ((op == OP_ADD) || (op == OP_OVF)) && ovf_raw;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes and a one-bit-per-cycle shifter.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
//
// state   | meaning
// S_IDLE  | no result held, ready for an op
// S_SHIFT | iterative shift in progress, upstream stalled
// S_DONE  | result valid, waiting for out_ready
module alu_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             busy
);

  localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             accept;
  logic             b_big;
  alu_op_e          op;
  logic [WIDTH-1:0] core_res;
  logic             core_zero, core_carry, core_ovf;

  assign op       = alu_op_e'(in_op);
  assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  // Full-width compare so large shift amounts are not aliased by truncation.
  assign b_big    = (in_b >= W_VAL);

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (in_a),
    .b      (in_b),
    .op     (op),
    .result (core_res),
    .zero   (core_zero),
    .carry  (core_carry),
    .ovf    (core_ovf)
  );

`ifdef ALU_FAST_SHIFT_EN
  logic [WIDTH-1:0] bshift;

  always_comb begin
    bshift = '0;
    if (!b_big) begin
      bshift = (op == OP_SLL) ? (in_a << in_b) : (in_a >> in_b);
    end
  end
`else
  logic [CNT_W-1:0] cnt_q, cnt_d, k;
  logic             left_q, left_d;
  logic [WIDTH-1:0] step;

  assign k    = b_big ? CNT_W'(WIDTH) : in_b[CNT_W-1:0];
  // The result register doubles as the shift working register while out_valid is low.
  assign step = left_q ? (res_q << 1) : (res_q >> 1);
`endif

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
`ifndef ALU_FAST_SHIFT_EN
    cnt_d   = cnt_q;
    left_d  = left_q;
`endif

    case (state_q)
`ifndef ALU_FAST_SHIFT_EN
      S_SHIFT: begin
        res_d = step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          zero_d  = ~|step;
        end
      end
`endif
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: ;
    endcase

    // A new accept overrides the DONE->IDLE transition for back-to-back issue.
    if (accept) begin
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      if (is_shift(op)) begin
`ifdef ALU_FAST_SHIFT_EN
        res_d   = bshift;
        zero_d  = ~|bshift;
        state_d = S_DONE;
`else
        res_d   = in_a;
        zero_d  = ~|in_a;
        left_d  = (op == OP_SLL);
        cnt_d   = k;
        state_d = (k == '0) ? S_DONE : S_SHIFT;
`endif
      end else begin
        res_d   = core_res;
        zero_d  = core_zero;
        carry_d = core_carry;
        ovf_d   = core_ovf;
        state_d = S_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      cnt_q   <= '0;
      left_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
`ifndef ALU_FAST_SHIFT_EN
      cnt_q   <= cnt_d;
      left_q  <= left_d;
`endif
    end
  end

  assign out_valid  = (state_q == S_DONE);
  assign out_result = res_q;
  assign out_zero   = zero_q;
  assign out_carry  = carry_q;
  assign out_ovf    = ovf_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: 8-bit instance with queued expectations, plus a 16-bit instance.
module tb_alu_seq;

  localparam int W = 8;
`ifdef ALU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_a, in_b, out_result;
  logic [2:0]    in_op;
  logic          out_zero, out_carry, out_ovf, busy;

  logic          in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0]   in_a16, in_b16, out_result16;
  logic [2:0]    in_op16;
  logic          out_zero16, out_carry16, out_ovf16, busy16;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         v;
    logic [31:0]  due;
  } exp_t;

  exp_t q[$];
  bit   head_seen = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero),
    .out_carry(out_carry), .out_ovf(out_ovf), .busy(busy)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .in_a(in_a16), .in_b(in_b16), .in_op(in_op16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .out_result(out_result16), .out_zero(out_zero16),
    .out_carry(out_carry16), .out_ovf(out_ovf16), .busy(busy16)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] op, input int base);
    exp_t       e;
    logic [W:0] s;
    logic       v;
    int         lat;
    e   = '0;
    lat = 0;
    s   = {1'b0, a} + {1'b0, b};
    v   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    case (op)
      3'd0: e.res = a & b;
      3'd1: begin e.res = s[W-1:0]; e.c = s[W]; e.v = v; end
      3'd2: e.res = a ^ b;
      3'd3: e.res[0] = (a < b);
      3'd4: begin e.res = (b >= W) ? '0 : (a << b); lat = (b >= W) ? W : int'(b); end
      3'd5: begin e.res = (b >= W) ? '0 : (a >> b); lat = (b >= W) ? W : int'(b); end
      3'd6: e.res[0] = (a != b);
      default: begin e.res[0] = v; e.v = v; end
    endcase
    e.z   = (e.res == '0);
    lat   = FAST ? 0 : lat;
    e.due = 32'(base + 1 + lat);
    return e;
  endfunction

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    int t = 0;
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    #1;
    while (!in_ready && t < 100) begin
      @(negedge clk); #1; t++;
    end
    chk("accept_wait", 64'(in_ready), 64'd1);
    if (in_ready) q.push_back(model(a, b, op, cyc));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk); t++;
    end
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] op, input logic [15:0] exp_res,
                       input logic exp_c, input int lat);
    int t = 0;
    in_a16 = a; in_b16 = b; in_op16 = op; in_valid16 = 1'b1;
    #1;
    chk({tag, "_rdy"}, 64'(in_ready16), 64'd1);
    @(negedge clk);
    in_valid16 = 1'b0;
    #1;
    while (!out_valid16 && t < 40) begin
      @(negedge clk); #1; t++;
    end
    chk({tag, "_lat"}, 64'(t), 64'(lat));
    chk({tag, "_res"}, 64'(out_result16), 64'(exp_res));
    chk({tag, "_carry"}, 64'(out_carry16), 64'(exp_c));
    @(negedge clk);
  endtask

  // Output monitor: latency on first sight of out_valid, values on handshake.
  initial begin
    forever begin
      @(negedge clk); #1;
      if (rst_n && out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", 64'd1, 64'd0);
        end else begin
          if (!head_seen) begin
            chk("latency", 64'(cyc), 64'(q[0].due));
            head_seen = 1'b1;
          end
          if (out_ready) begin
            chk("result", 64'(out_result), 64'(q[0].res));
            chk("zero",   64'(out_zero),   64'(q[0].z));
            chk("carry",  64'(out_carry),  64'(q[0].c));
            chk("ovf",    64'(out_ovf),    64'(q[0].v));
            void'(q.pop_front());
            head_seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic [2:0]   rop;
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b1;
    in_valid16 = 1'b0; in_a16 = '0; in_b16 = '0; in_op16 = '0; out_ready16 = 1'b1;
    #1;
    chk("rst_valid",  64'(out_valid),  64'd0);
    chk("rst_result", 64'(out_result), 64'd0);
    chk("rst_flags",  64'({out_zero, out_carry, out_ovf}), 64'd0);
    chk("rst_busy",   64'(busy),       64'd0);
    chk("rst_ready",  64'(in_ready),   64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    send(8'h7F, 8'h01, 3'd1);
    send(8'hFF, 8'h01, 3'd1);
    send(8'h80, 8'h80, 3'd7);
    send(8'h05, 8'h80, 3'd3);
    send(8'h3C, 8'h3C, 3'd6);
    drain();

    send(8'h81, 8'd3, 3'd4);
    #1;
    chk("shift_in_ready", 64'(in_ready), 64'(FAST));
    chk("shift_busy",     64'(busy),     64'd1);
    send(8'hFF, 8'd9, 3'd5);
    send(8'hA5, 8'd0, 3'd4);
    drain();

    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = W'($urandom);
      rb  = (rop == 3'd4 || rop == 3'd5) ? W'($urandom_range(0, W + 2)) : W'($urandom);
      send(ra, rb, rop);
    end
    drain();

    out_ready = 1'b0;
    send(8'h7F, 8'h01, 3'd1);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid",  64'(out_valid),  64'd1);
      chk("bp_result", 64'(out_result), 64'h80);
      chk("bp_flags",  64'({out_zero, out_carry, out_ovf}), 64'b001);
      chk("bp_ready",  64'(in_ready),   64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(8'hFF, 8'h01, 3'd1);
    drain();

    send(8'h55, 8'd6, 3'd4);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",  64'(out_valid),  64'd0);
    chk("mid_rst_result", 64'(out_result), 64'd0);
    chk("mid_rst_flags",  64'({out_zero, out_carry, out_ovf}), 64'd0);
    chk("mid_rst_busy",   64'(busy),       64'd0);
    q.delete();
    head_seen = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 64'(in_ready),  64'd1);
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    send(8'hA5, 8'd0, 3'd5);
    send(8'h3C, 8'hC3, 3'd2);
    drain();

    run16("w16_add", 16'hFFFF, 16'h0001, 3'd1, 16'h0000, 1'b1, 0);
    run16("w16_srl", 16'h8000, 16'd15,   3'd5, 16'h0001, 1'b0, FAST ? 0 : 15);
    run16("w16_sll", 16'h1234, 16'd40,   3'd4, 16'h0000, 1'b0, FAST ? 0 : 16);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
